mtrxc_lif_neuron: RTL and testbench
===================================

# mtrxc_lif_neuron

Downstream stage of the systolic array. Consumes the MtrxC partial-sum slice stream, integrates each element into a per-neuron membrane potential across T timesteps using a tau=2 leaky-integrate-and-fire rule, and emits one spike-bit slice per input slice. Sits between the systolic array output and the spike buffer feeding the next attention/MLP layer.

## Interface
- C_LANES, 16, elements per MtrxC slice
- PSUM_W, 16, signed partial-sum width per element; MtrxC data width = C_LANES*PSUM_W, element i at bits [i*PSUM_W +: PSUM_W]
- SLICES, 16, slices per timestep (rows of the output tile)
- T_STEPS, 4, timesteps per tile
- VTH, 256, signed firing threshold (PSUM_W bits)

Ports:
- s_clk  in  1  clock
- s_rst  in  1  reset, asynchronous, active-low
- MtrxC_slice_valid  in  1  input slice valid
- MtrxC_slice_data  in  C_LANES*PSUM_W  signed partial sums
- MtrxC_slice_done  in  1  marks last slice of a timestep
- MtrxC_slice_ready  out  1  input accept
- Spike_slice_valid  out  1  output valid
- Spike_slice_data  out  C_LANES  spike bit per lane
- Spike_slice_done  out  1  last slice of a timestep
- Spike_tile_last  out  1  last slice of the last timestep of a tile
- Spike_slice_ready  in  1  downstream accept
- protocol_err  out  1  sticky: done arrived on a row other than SLICES-1

## Operation
- Membrane store: SLICES x C_LANES registers, PSUM_W signed each; combinational read indexed by row counter; no reset needed.
- Counters: row (0..SLICES-1), tstep (0..T_STEPS-1).
- Accept = MtrxC_slice_valid && MtrxC_slice_ready.
- Per lane on accept: V = (tstep==0) ? 0 : mem[row][i]; D = psum - V in PSUM_W+1 bits; H = V + (D >>> 1) (arithmetic, floor). H always lies between V and psum, so no saturation. spike = (H >= VTH) signed. Write back 0 if spike else H.
- Counter update on accept: if done: row<=0, tstep<=(tstep==T_STEPS-1)?0:tstep+1; if done and row!=SLICES-1, set protocol_err. Else if row==SLICES-1 without done: row wraps to 0, tstep unchanged, protocol_err set. Else row<=row+1.
- Output register loaded on accept: data=spike vector, done=input done, tile_last=done && tstep==T_STEPS-1.
- Simultaneous output drain and new accept in same cycle: register reloads, no bubble.

## Timing
- Reset values: MtrxC_slice_ready 1 (once reset released), Spike_slice_valid 0, Spike_slice_data 0, Spike_slice_done 0, Spike_tile_last 0, protocol_err 0, row 0, tstep 0.
- Latency: 1 cycle, accept at edge k -> Spike_slice_valid high after edge k.
- MtrxC_slice_ready = !Spike_slice_valid || Spike_slice_ready (combinational from output state).
- Output held stable while valid && !ready; valid drops only after a handshake with no new accept.
- Full throughput: 1 slice/cycle with Spike_slice_ready held high.
- Reset mid-tile: counters to 0, pending output discarded; stale membrane harmless since tstep 0 ignores it.

## Structure
- Shared package (hyper_para.v): C_LANES, PSUM_W, SLICES, T_STEPS, VTH defaults, CLK_PERIOD.
- One natural sub-module: lif_lane (combinational V/psum -> H, spike, writeback value), instantiated C_LANES times.

## Test plan
- Reset: hold s_rst low -> all outputs 0; after release MtrxC_slice_ready=1, first slice output 1 cycle later.
- All lanes psum=300, 4 timesteps: H=150,225,262,150 -> spikes 0,0,1(writeback 0),0; Spike_tile_last only on row 15 of t=3.
- psum=-101 at t=0 -> H=-51, spike 0; next t psum=0 -> H=-51+(51>>>1)=-26.
- Backpressure: Spike_slice_ready low 5 cycles mid-stream -> MtrxC_slice_ready low, output data stable, no slice lost or duplicated over 16 slices.
- Early done on row 5 -> protocol_err sticks 1, row returns 0, tstep increments; next slice uses row 0 membrane.
- Two back-to-back tiles with psum=300: second tile t=0 yields H=150 (old membrane ignored), identical spike pattern to first.

Source files
------------

// File: rtl/mtrxc_lif_neuron_pkg.sv
// ----------------------------------------------------------------------------
// mtrxc_lif_neuron_pkg
// Shared defaults for the LIF neuron stage behind the systolic array:
// slice geometry, partial-sum width, timesteps per tile, firing threshold,
// and the output register state type.
// ----------------------------------------------------------------------------
package mtrxc_lif_neuron_pkg;

   localparam int unsigned C_LANES_DEF = 16;   // elements per MtrxC slice
   localparam int unsigned PSUM_W_DEF  = 16;   // signed partial-sum width
   localparam int unsigned SLICES_DEF  = 16;   // slices (rows) per timestep
   localparam int unsigned T_STEPS_DEF = 4;    // timesteps per tile
   localparam int          VTH_DEF     = 256;  // signed firing threshold
   localparam int unsigned CLK_PERIOD  = 10;   // nominal clock period (sim)

   // Output register occupancy
   typedef enum logic {
      OUT_EMPTY = 1'b0,
      OUT_FULL  = 1'b1
   } out_state_e;

   // Counter width that stays >= 1 even for a count of 1
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mtrxc_lif_neuron_lif_lane.sv
// ----------------------------------------------------------------------------
// lif_lane
// Combinational tau=2 leaky-integrate-and-fire update for one lane.
//   v_i     : membrane potential before this timestep (already zeroed at t=0)
//   psum_i  : incoming signed partial sum
//   spike_o : 1 when the updated potential reaches the threshold
//   wb_o    : value written back to the membrane (0 after a spike)
// ----------------------------------------------------------------------------
module lif_lane
   import mtrxc_lif_neuron_pkg::*;
#(
   parameter int unsigned PSUM_W = PSUM_W_DEF,
   parameter int          VTH    = VTH_DEF
) (
   input  logic signed [PSUM_W-1:0] v_i,
   input  logic signed [PSUM_W-1:0] psum_i,
   output logic                     spike_o,
   output logic signed [PSUM_W-1:0] wb_o
);

   localparam logic signed [PSUM_W-1:0] VTH_S = PSUM_W'(VTH);

   logic signed [PSUM_W:0]   v_x;
   logic signed [PSUM_W:0]   p_x;
   logic signed [PSUM_W:0]   d;
   logic signed [PSUM_W-1:0] h;

   // H = V + floor((psum - V)/2) lies between V and psum, so the truncation
   // back to PSUM_W bits can never overflow.
   always_comb begin
      v_x     = {v_i[PSUM_W-1], v_i};
      p_x     = {psum_i[PSUM_W-1], psum_i};
      d       = p_x - v_x;
      h       = PSUM_W'(v_x + (d >>> 1));
      spike_o = (h >= VTH_S);
      wb_o    = spike_o ? '0 : h;
   end

endmodule

// File: rtl/mtrxc_lif_neuron.sv
// ----------------------------------------------------------------------------
// mtrxc_lif_neuron
// Integrates MtrxC partial-sum slices into per-neuron membrane potentials
// over T_STEPS timesteps and emits one spike-bit slice per input slice.
//
// Ports
//   s_clk, s_rst          clock, asynchronous active-low reset
//   MtrxC_slice_valid     input slice valid
//   MtrxC_slice_data      C_LANES x PSUM_W signed partial sums (lane i at
//                         [i*PSUM_W +: PSUM_W])
//   MtrxC_slice_done      last slice of a timestep
//   MtrxC_slice_ready     input accept
//   Spike_slice_valid     output valid
//   Spike_slice_data      spike bit per lane
//   Spike_slice_done      last slice of a timestep
//   Spike_tile_last       last slice of the last timestep of a tile
//   Spike_slice_ready     downstream accept
//   protocol_err          sticky: done seen on a row other than SLICES-1, or
//                         row SLICES-1 seen without done
// ----------------------------------------------------------------------------
module mtrxc_lif_neuron
   import mtrxc_lif_neuron_pkg::*;
#(
   parameter int unsigned C_LANES = C_LANES_DEF,
   parameter int unsigned PSUM_W  = PSUM_W_DEF,
   parameter int unsigned SLICES  = SLICES_DEF,
   parameter int unsigned T_STEPS = T_STEPS_DEF,
   parameter int          VTH     = VTH_DEF
) (
   input  logic                        s_clk,
   input  logic                        s_rst,
   input  logic                        MtrxC_slice_valid,
   input  logic [C_LANES*PSUM_W-1:0]   MtrxC_slice_data,
   input  logic                        MtrxC_slice_done,
   output logic                        MtrxC_slice_ready,
   output logic                        Spike_slice_valid,
   output logic [C_LANES-1:0]          Spike_slice_data,
   output logic                        Spike_slice_done,
   output logic                        Spike_tile_last,
   input  logic                        Spike_slice_ready,
   output logic                        protocol_err
);

   localparam int unsigned      ROW_W    = cnt_w(SLICES);
   localparam int unsigned      TS_W     = cnt_w(T_STEPS);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SLICES - 1);
   localparam logic [TS_W-1:0]  TS_LAST  = TS_W'(T_STEPS - 1);

   logic [ROW_W-1:0]         row_q, row_d;
   logic [TS_W-1:0]          tstep_q, tstep_d;
   logic                     perr_q, perr_d;
   out_state_e               out_st_q, out_st_d;
   logic [C_LANES-1:0]       spk_q, spk_d;
   logic                     done_q, done_d;
   logic                     last_q, last_d;

   logic signed [PSUM_W-1:0] mem_q [SLICES][C_LANES];
   logic signed [PSUM_W-1:0] wb [C_LANES];
   logic [C_LANES-1:0]       spike_vec;
   logic                     out_valid;
   logic                     accept;

   assign out_valid = (out_st_q == OUT_FULL);

   // Ready is held low while reset is asserted so nothing is taken in
   // before the counters are known to be at zero.
   assign MtrxC_slice_ready = s_rst && (!out_valid || Spike_slice_ready);
   assign accept            = MtrxC_slice_valid && MtrxC_slice_ready;

   // ---------------------------------------------------------------- lanes
   for (genvar i = 0; i < C_LANES; i++) begin : g_lane
      logic signed [PSUM_W-1:0] v;

      // The first timestep of a tile starts from rest; whatever the store
      // holds from a previous tile (or before reset) is ignored.
      assign v = (tstep_q == '0) ? '0 : mem_q[row_q][i];

      lif_lane #(
         .PSUM_W (PSUM_W),
         .VTH    (VTH)
      ) u_lane (
         .v_i     (v),
         .psum_i  (MtrxC_slice_data[i*PSUM_W +: PSUM_W]),
         .spike_o (spike_vec[i]),
         .wb_o    (wb[i])
      );
   end

   // ------------------------------------------------------ membrane store
   always_ff @(posedge s_clk) begin
      if (accept) begin
         for (int unsigned i = 0; i < C_LANES; i++) begin
            mem_q[row_q][i] <= wb[i];
         end
      end
   end

   // ------------------------------------------------------------ counters
   always_comb begin
      row_d   = row_q;
      tstep_d = tstep_q;
      perr_d  = perr_q;
      if (accept) begin
         if (MtrxC_slice_done) begin
            row_d   = '0;
            tstep_d = (tstep_q == TS_LAST) ? '0 : tstep_q + 1'b1;
            if (row_q != ROW_LAST) begin
               perr_d = 1'b1;
            end
         end else if (row_q == ROW_LAST) begin
            // Missing done: wrap the row but stay in the same timestep
            row_d  = '0;
            perr_d = 1'b1;
         end else begin
            row_d = row_q + 1'b1;
         end
      end
   end

   // ----------------------------------------------------- output register
   always_comb begin
      out_st_d = out_st_q;
      spk_d    = spk_q;
      done_d   = done_q;
      last_d   = last_q;
      if (accept) begin
         // A drain and a new accept in the same cycle simply reload
         out_st_d = OUT_FULL;
         spk_d    = spike_vec;
         done_d   = MtrxC_slice_done;
         last_d   = MtrxC_slice_done && (tstep_q == TS_LAST);
      end else if (out_valid && Spike_slice_ready) begin
         out_st_d = OUT_EMPTY;
      end
   end

   always_ff @(posedge s_clk or negedge s_rst) begin
      if (!s_rst) begin
         row_q    <= '0;
         tstep_q  <= '0;
         perr_q   <= 1'b0;
         out_st_q <= OUT_EMPTY;
         spk_q    <= '0;
         done_q   <= 1'b0;
         last_q   <= 1'b0;
      end else begin
         row_q    <= row_d;
         tstep_q  <= tstep_d;
         perr_q   <= perr_d;
         out_st_q <= out_st_d;
         spk_q    <= spk_d;
         done_q   <= done_d;
         last_q   <= last_d;
      end
   end

   assign Spike_slice_valid = out_valid;
   assign Spike_slice_data  = spk_q;
   assign Spike_slice_done  = done_q;
   assign Spike_tile_last   = last_q;
   assign protocol_err      = perr_q;

endmodule

// File: tb/tb_mtrxc_lif_neuron.sv
// ----------------------------------------------------------------------------
// tb_mtrxc_lif_neuron
// Directed and randomized stimulus for mtrxc_lif_neuron, checked against an
// integer reference model of the leaky-integrate-and-fire rule.
// ----------------------------------------------------------------------------
module tb_mtrxc_lif_neuron;
   import mtrxc_lif_neuron_pkg::*;

   localparam int L = C_LANES_DEF;
   localparam int W = PSUM_W_DEF;
   localparam int S = SLICES_DEF;
   localparam int T = T_STEPS_DEF;

   logic             s_clk;
   logic             s_rst;
   logic             MtrxC_slice_valid;
   logic [L*W-1:0]   MtrxC_slice_data;
   logic             MtrxC_slice_done;
   logic             MtrxC_slice_ready;
   logic             Spike_slice_valid;
   logic [L-1:0]     Spike_slice_data;
   logic             Spike_slice_done;
   logic             Spike_tile_last;
   logic             Spike_slice_ready;
   logic             protocol_err;

   mtrxc_lif_neuron #(
      .C_LANES (L),
      .PSUM_W  (W),
      .SLICES  (S),
      .T_STEPS (T),
      .VTH     (VTH_DEF)
   ) dut (
      .s_clk             (s_clk),
      .s_rst             (s_rst),
      .MtrxC_slice_valid (MtrxC_slice_valid),
      .MtrxC_slice_data  (MtrxC_slice_data),
      .MtrxC_slice_done  (MtrxC_slice_done),
      .MtrxC_slice_ready (MtrxC_slice_ready),
      .Spike_slice_valid (Spike_slice_valid),
      .Spike_slice_data  (Spike_slice_data),
      .Spike_slice_done  (Spike_slice_done),
      .Spike_tile_last   (Spike_tile_last),
      .Spike_slice_ready (Spike_slice_ready),
      .protocol_err      (protocol_err)
   );

   initial s_clk = 1'b0;
   always #(CLK_PERIOD / 2) s_clk = ~s_clk;

   typedef struct {
      logic [L-1:0] data;
      logic         done;
      logic         last;
   } exp_t;

   exp_t expq[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Reference model state
   int   m_mem [S][L];
   int   m_row;
   int   m_tstep;
   bit   m_perr;
   int   exp_last_cnt = 0;
   int   obs_last_cnt = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
   endtask

   function automatic int floor_half(input int d);
      return (d >= 0) ? d / 2 : -((1 - d) / 2);
   endfunction

   function automatic int rand_psum();
      case ($urandom_range(0, 2))
         0:       return int'($urandom_range(0, 65535)) - 32768;
         1:       return int'($urandom_range(0, 800)) - 200;
         default: return int'($urandom_range(0, 600));
      endcase
   endfunction

   task automatic model_accept(input int p[L], input bit done);
      exp_t e;
      int   v, h;
      for (int i = 0; i < L; i++) begin
         v = (m_tstep == 0) ? 0 : m_mem[m_row][i];
         h = v + floor_half(p[i] - v);
         e.data[i]         = (h >= VTH_DEF);
         m_mem[m_row][i]   = (h >= VTH_DEF) ? 0 : h;
      end
      e.done = done;
      e.last = done && (m_tstep == T - 1);
      if (e.last) exp_last_cnt++;
      expq.push_back(e);
      if (done) begin
         if (m_row != S - 1) m_perr = 1'b1;
         m_row   = 0;
         m_tstep = (m_tstep + 1) % T;
      end else if (m_row == S - 1) begin
         m_row  = 0;
         m_perr = 1'b1;
      end else begin
         m_row++;
      end
   endtask

   // Present one slice, wait (bounded) for acceptance, update the model.
   task automatic send(input int p[L], input bit done);
      int waited = 0;
      MtrxC_slice_valid = 1'b1;
      MtrxC_slice_done  = done;
      for (int i = 0; i < L; i++) MtrxC_slice_data[i*W +: W] = W'(p[i]);
      forever begin
         @(negedge s_clk);
         if (MtrxC_slice_ready) break;
         waited++;
         if (waited > 50) begin
            check("accept_timeout", MtrxC_slice_ready, 1);
            MtrxC_slice_valid = 1'b0;
            return;
         end
      end
      model_accept(p, done);
      @(posedge s_clk);
      #1;
      MtrxC_slice_valid = 1'b0;
      check("valid_after_accept", Spike_slice_valid, 1);
      check("protocol_err", protocol_err, m_perr);
   endtask

   // ------------------------------------------------------------ monitor
   logic [L-1:0] hold_data;
   bit           stalled = 0;

   always @(negedge s_clk) begin
      exp_t e;
      if (Spike_slice_valid && !Spike_slice_ready) begin
         check("bp_ready_low", MtrxC_slice_ready, 0);
         if (stalled) check("bp_data_stable", Spike_slice_data, hold_data);
         stalled   = 1;
         hold_data = Spike_slice_data;
      end else begin
         stalled = 0;
      end
      if (Spike_slice_valid && Spike_slice_ready) begin
         check("output_expected", expq.size() > 0, 1);
         if (expq.size() > 0) begin
            e = expq.pop_front();
            check("spike_data", Spike_slice_data, e.data);
            check("spike_done", Spike_slice_done, e.done);
            check("tile_last",  Spike_tile_last,  e.last);
            if (Spike_tile_last) obs_last_cnt++;
         end
      end
   end

   // ------------------------------------------------------------ stimulus
   int p[L];

   initial begin
      s_rst             = 1'b0;
      MtrxC_slice_valid = 1'b0;
      MtrxC_slice_data  = '0;
      MtrxC_slice_done  = 1'b0;
      Spike_slice_ready = 1'b1;
      m_row = 0; m_tstep = 0; m_perr = 0;

      // Reset state
      repeat (3) @(posedge s_clk);
      @(negedge s_clk);
      check("rst_valid", Spike_slice_valid, 0);
      check("rst_data",  Spike_slice_data,  0);
      check("rst_done",  Spike_slice_done,  0);
      check("rst_last",  Spike_tile_last,   0);
      check("rst_perr",  protocol_err,      0);
      check("rst_ready", MtrxC_slice_ready, 0);
      s_rst = 1'b1;
      #1;
      check("ready_after_rst", MtrxC_slice_ready, 1);
      @(posedge s_clk);
      #1;

      // Two back-to-back tiles of psum=300: H=150,225,262,150
      for (int tile = 0; tile < 2; tile++) begin
         for (int t = 0; t < T; t++) begin
            for (int r = 0; r < S; r++) begin
               for (int i = 0; i < L; i++) p[i] = 300;
               send(p, r == S - 1);
               check("c300_spikes", Spike_slice_data, (t == 2) ? 16'hFFFF : 16'h0000);
               check("c300_last", Spike_tile_last, (t == T - 1) && (r == S - 1));
            end
         end
      end

      // Negative membrane: -101 -> -51, 0 -> -26, then 537/538 straddle VTH
      for (int t = 0; t < T; t++) begin
         for (int r = 0; r < S; r++) begin
            for (int i = 0; i < L; i++) begin
               case (t)
                  0:       p[i] = -101;
                  1:       p[i] = 0;
                  2:       p[i] = 537 + (i % 2);
                  default: p[i] = 300;
               endcase
            end
            send(p, r == S - 1);
            if (t == 2) check("neg_t2_spikes", Spike_slice_data, 16'hAAAA);
         end
      end

      // Backpressure: downstream stalls for 5 cycles mid-timestep
      fork
         begin
            repeat (4) @(posedge s_clk);
            #1 Spike_slice_ready = 1'b0;
            repeat (5) @(posedge s_clk);
            #1 Spike_slice_ready = 1'b1;
         end
      join_none
      for (int r = 0; r < S; r++) begin
         for (int i = 0; i < L; i++) p[i] = rand_psum();
         send(p, r == S - 1);
      end

      // Random traffic for the rest of that tile and one more tile
      for (int t = 0; t < 2 * T - 1; t++) begin
         for (int r = 0; r < S; r++) begin
            for (int i = 0; i < L; i++) p[i] = rand_psum();
            send(p, r == S - 1);
         end
      end

      // Early done on row 5, then continue with row-0 membrane
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < L; i++) p[i] = rand_psum();
         send(p, r == 5);
      end
      check("perr_early_done", protocol_err, 1);
      for (int r = 0; r < S; r++) begin
         for (int i = 0; i < L; i++) p[i] = rand_psum();
         send(p, r == S - 1);
      end
      check("perr_sticky", protocol_err, 1);

      // Reset mid-tile: pending output discarded, counters cleared
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < L; i++) p[i] = rand_psum();
         send(p, 1'b0);
      end
      s_rst = 1'b0;
      #1;
      check("midrst_valid", Spike_slice_valid, 0);
      check("midrst_perr",  protocol_err,      0);
      check("midrst_ready", MtrxC_slice_ready, 0);
      expq.delete();
      m_row = 0; m_tstep = 0; m_perr = 0;
      @(negedge s_clk);
      s_rst = 1'b1;
      @(posedge s_clk);
      #1;
      for (int t = 0; t < T; t++) begin
         for (int r = 0; r < S; r++) begin
            for (int i = 0; i < L; i++) p[i] = (t == 0) ? 300 : rand_psum();
            send(p, r == S - 1);
            if (t == 0) check("post_rst_t0", Spike_slice_data, 16'h0000);
         end
      end

      // Drain
      MtrxC_slice_valid = 1'b0;
      repeat (4) @(posedge s_clk);
      #1;
      check("queue_drained", expq.size(), 0);
      check("tile_last_count", obs_last_cnt, exp_last_cnt);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
